// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Fetch PC generator / redirect controller with one-entry
//               IF/ID holding buffer. Optional macro: NPC_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_npc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic        req;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q && id_stall;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    req        = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        req = !ex_is_jump && !(if_valid_q && id_stall);
        if (req && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
          // A same-cycle redirect drops the response instead of arming kill.
          if (!kill_q && !ex_is_jump) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_inst_d  = imem_rdata;
          end
        end else if (ex_is_jump) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (ex_is_jump) begin
      pc_d       = {ex_npc[31:2], 2'b00};
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_pc4     = if_pc_q + 32'd4;
  assign if_inst    = if_inst_q;
  assign flush_ifid = ex_is_jump;
  assign flush_idex = ex_is_jump;

`ifdef NPC_ALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = ex_is_jump && (ex_npc[1:0] != 2'b00);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  logic unused_npc_lsb;
  assign unused_npc_lsb = ^ex_npc[1:0];
  assign misalign       = 1'b0;
`endif

endmodule
`default_nettype wire
